apb_regfile_slave: RTL

//  Parametrised APB4 register-file slave; next generation of the simple always-ready slave.

---
 rtl/apb_regfile_pkg.sv | 30 +++
 rtl/apb_wait_ctr.sv | 31 +++
 rtl/apb_regfile_slave.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register-file slave.
package apb_regfile_pkg;

  // Bus-side transfer state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Software access type of one register.
  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_RO  = 2'd1,
    ACC_W1C = 2'd2
  } acc_e;

  // Largest register count the mask helper can describe.
  localparam int MAX_REGS = 256;

  // Access type of register idx; read-only takes priority over W1C.
  function automatic acc_e acc_type(input int idx,
                                    input logic [MAX_REGS-1:0] ro_mask,
                                    input logic [MAX_REGS-1:0] w1c_mask);
    if (ro_mask[idx[7:0]])       return ACC_RO;
    else if (w1c_mask[idx[7:0]]) return ACC_W1C;
    else                         return ACC_RW;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: loaded at the start of a transfer, counts down to zero.
module apb_wait_ctr
  import apb_regfile_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CW-1:0] r_cnt;

  // Load on SETUP, count down while nonzero during ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(WAIT_STATES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 register-file slave with address window, wait states, RW/RO/W1C
// registers, hardware-set status bits and a registered level interrupt.
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int unsigned                  ADDR_WIDTH  = 32,
  parameter int unsigned                  DATA_WIDTH  = 32,
  parameter int unsigned                  NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR   = '0,
  parameter int unsigned                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]          RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]          W1C_MASK    = '0
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_val,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           irq
);

  localparam int DW = DATA_WIDTH;
  localparam int NB = DATA_WIDTH / 8;

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_load;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_idx_full;
  logic                  w_below;
  logic                  w_oob;
  logic                  w_misal;
  logic                  w_ro_hit;
  logic                  w_err_cond;
  logic                  w_wr_en;
  logic [DW-1:0]         w_strb_mask;
  logic [DW-1:0]         w_rd_mux;
  logic [DW-1:0]         w_regs     [NUM_REGS];
  logic [DW-1:0]         w_rd_terms [NUM_REGS];
  logic [NUM_REGS-1:0]   w_ro_sel;
  logic [NUM_REGS-1:0]   w_w1c_any;
  logic                  r_irq;

  apb_wait_ctr #(.WAIT_STATES(WAIT_STATES)) u_wait_ctr (
    .pclk    (pclk),
    .presetn (presetn),
    .i_load  (w_load),
    .i_dec   (r_state == ACCESS),
    .o_done  (w_done)
  );

  // Transfer state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; a dropped psel/penable in ACCESS aborts the transfer.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) w_state_next = SETUP;
      end
      SETUP: begin
        w_load       = 1'b1;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        if (!(psel && penable)) w_state_next = IDLE;
        else if (w_done)        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Address decode at full address width so out-of-window addresses never alias.
  assign w_off      = paddr - BASE_ADDR;
  assign w_idx_full = w_off >> 2;
  assign w_below    = (paddr < BASE_ADDR);
  assign w_oob      = (w_idx_full >= ADDR_WIDTH'(NUM_REGS));
  assign w_misal    = (paddr[1:0] != 2'b00);
  assign w_ro_hit   = !w_below && !w_oob && (|w_ro_sel);
  assign w_err_cond = w_below || w_oob || w_misal || (pwrite && w_ro_hit);

  assign pready  = (r_state == ACCESS) && w_done && psel && penable;
  assign pslverr = pready && w_err_cond;
  assign w_wr_en = pready && pwrite && !w_err_cond;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_strb
      assign w_strb_mask[gi*8 +: 8] = {8{pstrb[gi]}};
    end

    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam acc_e ACC = acc_type(gi, MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK));
      logic w_sel;
      logic w_hit;
      assign w_sel = (w_idx_full == ADDR_WIDTH'(gi));
      assign w_hit = w_wr_en && w_sel;

      if (ACC == ACC_RO) begin : g_ro
        assign w_regs[gi]     = '0;
        assign w_ro_sel[gi]   = w_sel;
        assign w_w1c_any[gi]  = 1'b0;
        assign w_rd_terms[gi] = w_sel ? hw_val[gi*DW +: DW] : '0;
      end else if (ACC == ACC_W1C) begin : g_w1c
        logic [DW-1:0] r_val;
        logic [DW-1:0] w_clr;
        assign w_clr = w_hit ? (pwdata & w_strb_mask) : '0;
        // Status bits: software clears, hardware sets; a same-cycle set wins.
        always_ff @(posedge pclk or negedge presetn) begin
          if (!presetn) r_val <= '0;
          else          r_val <= (r_val & ~w_clr) | hw_set[gi*DW +: DW];
        end
        assign w_regs[gi]     = r_val;
        assign w_ro_sel[gi]   = 1'b0;
        assign w_w1c_any[gi]  = |r_val;
        assign w_rd_terms[gi] = w_sel ? r_val : '0;
      end else begin : g_rw
        logic [DW-1:0] r_val;
        // Plain control register with byte-strobed writes.
        always_ff @(posedge pclk or negedge presetn) begin
          if (!presetn)   r_val <= '0;
          else if (w_hit) r_val <= (r_val & ~w_strb_mask) | (pwdata & w_strb_mask);
        end
        assign w_regs[gi]     = r_val;
        assign w_ro_sel[gi]   = 1'b0;
        assign w_w1c_any[gi]  = 1'b0;
        assign w_rd_terms[gi] = w_sel ? r_val : '0;
      end

      assign reg_q[gi*DW +: DW] = w_regs[gi];
    end
  endgenerate

  // Read mux: at most one term is nonzero, so an OR tree selects it.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) w_rd_mux = w_rd_mux | w_rd_terms[i];
  end

  assign prdata = (pready && !pwrite && !w_err_cond) ? w_rd_mux : '0;

  // Level interrupt from any set W1C bit, one cycle behind register state.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_irq <= 1'b0;
    else          r_irq <= |w_w1c_any;
  end

  assign irq = r_irq;

endmodule
